// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: syncs, display enable,
// pixel coordinates and line/frame strobes from one pixel clock.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          pix_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display_en,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  // inclusive ends avoid wrap when a zero back porch puts the end at 2^CW
  localparam logic [CW-1:0] HS_LST =
    CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LST =
    CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;

  always_comb begin
    h_wrap = (pix_x == H_LAST);
    h_nxt  = h_wrap ? '0 : pix_x + 1'b1;
    v_nxt  = pix_y;
    if (h_wrap)
      v_nxt = (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
  end

  // outputs decode the next-state counters so they align with pix_x/pix_y
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pix_x       <= H_LAST;
      pix_y       <= V_LAST;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      display_en  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      pix_x       <= h_nxt;
      pix_y       <= v_nxt;
      h_sync      <= (h_nxt >= HS_BEG && h_nxt <= HS_LST)
                     ? H_POL : ~H_POL;
      v_sync      <= (v_nxt >= VS_BEG && v_nxt <= VS_LST)
                     ? V_POL : ~V_POL;
      display_en  <= (h_nxt < HA) && (v_nxt < VA);
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny
// active-high instance with zero-width porches for whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic pix_en = 1'b1;

  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x, d_y;
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0] s_x, s_y;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .nrst(nrst), .pix_en(pix_en),
    .h_sync(d_hs), .v_sync(d_vs), .display_en(d_de),
    .pix_x(d_x), .pix_y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // 13 x 7 raster, H_BP = 0 and V_FP = 0, active-high syncs
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(0),
    .V_ACTIVE(4), .V_FP(0), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) dut_s (
    .clk(clk), .nrst(nrst), .pix_en(pix_en),
    .h_sync(s_hs), .v_sync(s_vs), .display_en(s_de),
    .pix_x(s_x), .pix_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check(input string tag,
                       input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_n, hs_first, hs_last, de639, de640, y799;
    int fs_n, period, vs_n, vs_first, vs_x, vs_y, hs2, de2;

    nrst = 1'b0;
    pix_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_x", d_x, 799);
    check("rst_y", d_y, 524);
    check("rst_hs", d_hs, 1);
    check("rst_vs", d_vs, 1);
    check("rst_de", d_de, 0);
    check("rst_ls", d_ls, 0);
    check("rst_fs", d_fs, 0);
    check("rst_s_x", s_x, 12);
    check("rst_s_y", s_y, 6);
    check("rst_s_hs", s_hs, 0);
    check("rst_s_vs", s_vs, 0);

    nrst = 1'b1;
    @(negedge clk);
    check("first_x", d_x, 0);
    check("first_y", d_y, 0);
    check("first_fs", d_fs, 1);
    check("first_ls", d_ls, 1);
    check("first_de", d_de, 1);
    check("first_s_x", s_x, 0);
    check("first_s_fs", s_fs, 1);

    // one full default line
    hs_n = 0; hs_first = -1; hs_last = -1;
    de639 = -1; de640 = -1; y799 = -1;
    for (int i = 0; i < 800; i++) begin
      if (!d_hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      if (d_x == 11'd639) de639 = int'(d_de);
      if (d_x == 11'd640) de640 = int'(d_de);
      if (d_x == 11'd799) y799 = int'(d_y);
      @(negedge clk);
    end
    check("hs_width", hs_n, 96);
    check("hs_first", hs_first, 656);
    check("hs_last", hs_last, 751);
    check("de_639", de639, 1);
    check("de_640", de640, 0);
    check("y_at_799", y799, 0);
    check("wrap_x", d_x, 0);
    check("wrap_y", d_y, 1);
    check("wrap_ls", d_ls, 1);
    check("wrap_fs", d_fs, 0);
    check("line1_vs", d_vs, 1);

    // two whole frames of the small instance
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    fs_n = 0; period = -1; vs_n = 0; vs_first = -1;
    vs_x = -1; vs_y = -1; hs2 = 0; de2 = 0;
    for (int i = 0; i < 182; i++) begin
      if (s_fs) begin
        fs_n++;
        if (fs_n == 2) period = i;
      end
      if (s_vs) begin
        vs_n++;
        if (vs_first < 0) begin
          vs_first = i;
          vs_x = int'(s_x);
          vs_y = int'(s_y);
        end
      end
      if (s_hs) hs2++;
      if (s_de) de2++;
      @(negedge clk);
    end
    check("s_fs_count", fs_n, 2);
    check("s_period", period, 91);
    check("s_vs_count", vs_n, 52);
    check("s_vs_first", vs_first, 52);
    check("s_vs_x", vs_x, 0);
    check("s_vs_y", vs_y, 4);
    check("s_hs_count", hs2, 42);
    check("s_de_count", de2, 64);
    check("s_end_x", s_x, 0);
    check("s_end_fs", s_fs, 1);

    // reset overrides a low pix_en, then stall pattern
    nrst = 1'b0;
    pix_en = 1'b0;
    @(negedge clk);
    check("rst_noen_x", d_x, 799);
    check("rst_noen_y", d_y, 524);
    nrst = 1'b1;
    pix_en = 1'b1;
    @(negedge clk);
    check("en1_x", d_x, 0);
    check("en1_ls", d_ls, 1);
    pix_en = 1'b0;
    @(negedge clk);
    check("en0_x", d_x, 0);
    check("en0_ls", d_ls, 1);
    check("en0_fs", d_fs, 1);
    pix_en = 1'b1;
    @(negedge clk);
    check("en2_x", d_x, 1);
    check("en2_ls", d_ls, 0);
    pix_en = 1'b0;
    @(negedge clk);
    check("en3_x", d_x, 1);

    // run on to x=300 and reset mid-line
    pix_en = 1'b1;
    repeat (299) @(negedge clk);
    check("mid_x", d_x, 300);
    check("mid_y", d_y, 0);
    check("mid_s_x", s_x, 1);
    check("mid_s_y", s_y, 2);
    nrst = 1'b0;
    @(negedge clk);
    check("mrst_x", d_x, 799);
    check("mrst_y", d_y, 524);
    check("mrst_hs", d_hs, 1);
    check("mrst_de", d_de, 0);
    check("mrst_fs", d_fs, 0);
    check("mrst_s_x", s_x, 12);
    check("mrst_s_hs", s_hs, 0);
    check("mrst_s_vs", s_vs, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("rel_x", d_x, 0);
    check("rel_y", d_y, 0);
    check("rel_fs", d_fs, 1);
    check("rel_s_fs", s_fs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; next generation of the fixed 640x480 sync-line block.
- Produces H/V sync with programmable polarity, a display-enable, pixel coordinates and line/frame strobes from one pixel-rate clock, plus a clock enable for divided pixel rates.
- Sits between the top-level clock/reset and the pixel source and framebuffer reader. All outputs are registered.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, H_SYNC asserted level (0 = active-low, 1 = active-high)
- V_POL, 0, V_SYNC asserted level
- CW, 11, counter/coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- CLK  in  1  pixel-domain clock, rising edge
- NRST  in  1  synchronous reset, active-low
- PIX_EN  in  1  pixel-advance enable; counters step only on edges where it is 1
- H_SYNC  out  1  horizontal sync, asserted level = H_POL
- V_SYNC  out  1  vertical sync, asserted level = V_POL
- DISPLAY_EN  out  1  high while the raster position is in the active area
- PIX_X  out  CW  horizontal position (h counter)
- PIX_Y  out  CW  vertical position (v counter)
- LINE_START  out  1  high while h = 0
- FRAME_START  out  1  high while h = 0 and v = 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- h region order: active [0, H_ACTIVE); front porch; sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); back porch up to H_TOTAL-1.
- v regions use the same order with the V_* parameters, in line units.
- Counters: on an edge with NRST=1 and PIX_EN=1:
  - h = (h == H_TOTAL-1) ? 0 : h+1.
  - v advances only when h wraps: v = (v == V_TOTAL-1) ? 0 : v+1.
- With PIX_EN=0, every register, including all outputs, holds its value.
- Outputs are registered and decoded from the next-state counters, so they describe exactly the position shown on PIX_X/PIX_Y in the same cycle. There is no skew between coordinates, syncs and DISPLAY_EN.
- Output decode:
  - H_SYNC = H_POL when h is in the h sync region, else ~H_POL.
  - V_SYNC = V_POL when v is in the v sync region, else ~V_POL. V_SYNC depends only on v, so it changes on the same edge as the v increment (at h = 0).
  - DISPLAY_EN = (h < H_ACTIVE) && (v < V_ACTIVE).
- Strobes: LINE_START and FRAME_START are position levels. Under PIX_EN stalls they stay high for multiple cycles, so consumers qualify them with PIX_EN.
- Reset: on an edge with NRST=0, regardless of PIX_EN:
  - h = H_TOTAL-1, v = V_TOTAL-1, i.e. the last back-porch pixel of the frame.
  - H_SYNC = ~H_POL, V_SYNC = ~V_POL, DISPLAY_EN = 0, LINE_START = 0, FRAME_START = 0.
  - PIX_X = H_TOTAL-1, PIX_Y = V_TOTAL-1.
- First enabled edge after reset moves to (0,0) with FRAME_START = LINE_START = DISPLAY_EN = 1.
- Reset mid-frame: takes effect on the next edge and overrides PIX_EN. No partial line is completed.
- Arithmetic: all comparisons are unsigned at CW bits. Counters never exceed TOTAL-1. The no-overflow guarantee comes from the CW constraint and holds without saturation logic.
- Zero-width porches (FP or BP = 0) are legal; regions simply abut. Sync width must be >= 1.

Test Plan:
- Default params, PIX_EN=1, reset released → 1st edge PIX_X=0, PIX_Y=0, FRAME_START=1, DISPLAY_EN=1; PIX_X=639 then 640 → DISPLAY_EN drops to 0 at 640.
- Default params, one line → H_SYNC low exactly for PIX_X 656..751 (96 cycles); PIX_X wraps 799→0 and PIX_Y increments on that same edge.
- Default params, full frame → V_SYNC low for PIX_Y 490..491 (2×800 cycles); frame period 420000 cycles; FRAME_START once per frame.
- H_POL=1, V_POL=1 → sync pulses high with identical timing; both syncs low during reset.
- PIX_EN toggled 1,0,1,0 → counters advance every other cycle; LINE_START held high for 2 cycles at h=0.
- Assert NRST=0 at PIX_X=300, PIX_Y=200 → next edge PIX_X=799, PIX_Y=524, all outputs inactive; release → (0,0) with FRAME_START=1.
